mult_out_fifo: RTL and testbench
================================

MULT_OUT_FIFO -- requirements
Module: mult_out_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 24, width of one product word.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  pipeline stage presents a product word this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  product word from the multiplier pipeline register.
REQ-007 SHALL have port out_valid  output  1  head word available to consumer.
REQ-008 SHALL have port out_ready  input  1  consumer accepts head word this cycle.
REQ-009 SHALL have port out_data  output  DATA_W  head word; valid only while out_valid=1.
REQ-010 SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky flag: a word was dropped.

Function
REQ-012 SHALL push in_data when in_valid=1 and (level<DEPTH, or a pop occurs in the same cycle).
REQ-013 SHALL pop when out_valid=1 and out_ready=1; out_ready with out_valid=0 has no effect.
REQ-014 SHALL present show-ahead data: out_data equals the oldest stored word whenever out_valid=1.
REQ-015 SHALL have write-to-read latency of 1 cycle: a word pushed at edge N is visible at out_data after edge N; no combinational in_data->out_data path.
REQ-016 SHALL drive out_valid=1 exactly when level>0.
REQ-017 SHALL update level by +1 (push only), -1 (pop only), 0 (both or neither).
REQ-018 SHALL, when full with simultaneous push and pop, pop the head and store the new word; level stays DEPTH, overflow unchanged.
REQ-019 SHALL, when empty with in_valid=1 and out_ready=1, push only (no bypass); level becomes 1.
REQ-020 SHALL, on in_valid=1 while full and no pop, drop in_data, keep contents unchanged, set overflow=1.
REQ-021 SHALL hold overflow=1 until reset.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; full/empty derived from level, not pointer equality alone.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-024 SHALL, on rst_n=0 at any time, asynchronously clear pointers, level=0, out_valid=0, overflow=0; stored data need not be cleared; out_data=0.
REQ-025 SHALL discard all buffered words on reset mid-operation; first push after rst_n rises is the first word seen.

Configuration
REQ-026 SHALL, when macro MULT_OUT_FIFO_STATS_EN is defined, add output max_level (clog2(DEPTH)+1 bits) holding the highest level reached since reset, reset to 0.
REQ-027 SHALL, when MULT_OUT_FIFO_STATS_EN is undefined, omit max_level port and its logic; all other behaviour identical.

Structure
REQ-028 SHALL take DATA_W default (24) and the level-width helper function from shared package mult_pkg.
REQ-029 SHALL place storage array and pointers in sub-module mult_fifo_mem (registered write, asynchronous read by address); control in mult_out_fifo.

Verification
REQ-030 Single word: reset, in_valid=1 in_data=24'hABCDEF one cycle, out_ready=0 -> next cycle out_valid=1, out_data=24'hABCDEF, level=1.
REQ-031 Fill/drain: push 24'h000001..24'h000004 with out_ready=0 -> level=4; then out_ready=1 -> outputs 1,2,3,4 in order on consecutive cycles, then out_valid=0.
REQ-032 Overflow: full with 1..4, push 24'h000005 with out_ready=0 -> 5 dropped, overflow=1, level=4; drain yields 1..4; overflow stays 1.
REQ-033 Full push+pop: full with 1..4, in_valid=1 data 24'h000009 and out_ready=1 -> pops 1, level=4, overflow=0; drain yields 2,3,4,9.
REQ-034 Wrap: 10 words streamed with in_valid and out_ready both 1 continuously -> all 10 delivered in order, level never exceeds 1, no overflow.
REQ-035 Reset mid-run: level=3, assert rst_n=0 asynchronously -> out_valid=0, level=0, overflow=0 immediately; with STATS_EN, max_level=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier output path: default product width
// and the occupancy-counter width helper.
package mult_pkg;

  localparam int DEFAULT_DATA_W = 24;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the address width.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mult_fifo_mem.sv
// Storage array with wrapping read/write pointers for mult_out_fifo.
// Registered write, asynchronous read at the read pointer (show-ahead head).
module mult_fifo_mem
  import mult_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the array is deliberately not reset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/mult_out_fifo.sv
// Show-ahead output FIFO for the multiplier pipeline, with sticky drop flag.
// Optional MULT_OUT_FIFO_STATS_EN adds a max_level high-water-mark output.
module mult_out_fifo
  import mult_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [level_width(DEPTH)-1:0] level,
`ifdef MULT_OUT_FIFO_STATS_EN
  output logic [level_width(DEPTH)-1:0] max_level,
`endif
  output logic                          overflow
);

  localparam int LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              r_overflow;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rd_data;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push  = in_valid && (!w_full || w_pop);

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (w_pop && !w_push) w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      if (in_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  mult_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_push),
    .wr_data (in_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data)
  );

  assign out_valid = !w_empty;
  // Mask the unreset array so out_data reads 0 whenever nothing is stored.
  assign out_data  = w_empty ? '0 : w_rd_data;
  assign level     = r_level;
  assign overflow  = r_overflow;

`ifdef MULT_OUT_FIFO_STATS_EN
  logic [LVL_W-1:0] r_max_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_level <= '0;
    end else if (w_level_nxt > r_max_level) begin
      r_max_level <= w_level_nxt;
    end
  end

  assign max_level = r_max_level;
`endif

endmodule

// File: tb/tb_mult_out_fifo.sv
// Directed self-checking bench for mult_out_fifo (DATA_W=24, DEPTH=4).
module tb_mult_out_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [2:0]  level;
  logic        overflow;
`ifdef MULT_OUT_FIFO_STATS_EN
  logic [2:0]  max_level;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mult_out_fifo #(
    .DATA_W (24),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
`ifdef MULT_OUT_FIFO_STATS_EN
    .max_level (max_level),
`endif
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [23:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic fill_1_to_4();
    for (int i = 1; i <= 4; i++) push(24'(i));
  endtask

  task automatic drain_expect(input string tag, input logic [23:0] exp [4]);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp[i]));
      step();
    end
    out_ready = 1'b0;
    check({tag, "_empty_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_empty_level"}, 32'(level), 32'd0);
  endtask

  logic [23:0] seq_1234 [4] = '{24'd1, 24'd2, 24'd3, 24'd4};
  logic [23:0] seq_2349 [4] = '{24'd2, 24'd3, 24'd4, 24'd9};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    step();

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
`ifdef MULT_OUT_FIFO_STATS_EN
    check("rst_max", 32'(max_level), 32'd0);
`endif

    // Single word, then out_ready on empty has no effect
    push(24'hABCDEF);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hABCDEF);
    check("single_level", 32'(level), 32'd1);
    step();
    check("single_hold", 32'(out_data), 32'hABCDEF);
    out_ready = 1'b1;
    step();
    check("single_pop_valid", 32'(out_valid), 32'd0);
    step();
    check("ready_empty_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    // Fill and drain
    fill_1_to_4();
    check("fill_level", 32'(level), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd0);
`ifdef MULT_OUT_FIFO_STATS_EN
    check("fill_max", 32'(max_level), 32'd4);
`endif
    drain_expect("drain", seq_1234);

    // Overflow: the fifth word is dropped and the flag sticks
    fill_1_to_4();
    push(24'd5);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_head", 32'(out_data), 32'd1);
    drain_expect("ovf_drain", seq_1234);
    check("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    fill_1_to_4();
    in_valid  = 1'b1;
    in_data   = 24'd9;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fpp_level", 32'(level), 32'd4);
    check("fpp_ovf", 32'(overflow), 32'd0);
    drain_expect("fpp_drain", seq_2349);

    // Continuous stream across pointer wrap
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 24'(16'h100 + k);
      step();
      check($sformatf("wrap_data%0d", k), 32'(out_data), 32'(16'h100 + k));
      check($sformatf("wrap_level%0d", k), 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("wrap_end_level", 32'(level), 32'd0);
    check("wrap_ovf", 32'(overflow), 32'd0);

    // Reset mid-run with overflow set and three words stored
    fill_1_to_4();
    push(24'd5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mid_level", 32'(level), 32'd3);
    check("mid_ovf", 32'(overflow), 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
`ifdef MULT_OUT_FIFO_STATS_EN
    check("mid_rst_max", 32'(max_level), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    push(24'h000077);
    check("post_rst_data", 32'(out_data), 32'h77);
    check("post_rst_level", 32'(level), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
